hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
Stall and flush controller for the 5-stage RV32 subset pipeline (R-type, I-type ALU, LW, SW, BEQ; branch resolved in ID). It keeps a two-deep shadow of the EX and MEM stages' destination and load information, and from it detects load-use and branch-operand hazards. It drives NoOp_i into the control decoder (bubble insertion), the PC/IF-ID hold, and the IF/ID flush on a taken branch. It also keeps saturating stall and flush performance counters.

Parameters:
REG_AW, 5, register-address width
CNT_W, 32, width of each performance counter

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous reset, active-high
ID_Op_i  in  7  opcode of the instruction in ID (IF/ID[6:0])
ID_rs1_i  in  REG_AW  rs1 field of the ID instruction
ID_rs2_i  in  REG_AW  rs2 field of the ID instruction
ID_rd_i  in  REG_AW  rd field of the ID instruction
Branch_taken_i  in  1  BEQ comparison result in ID; meaningful only when ID_Op_i is BEQ
NoOp_o  out  1  to the control decoder; zeroes the ID/EX control bits
Stall_o  out  1  hold the IF/ID register
PCWrite_o  out  1  PC write enable
Flush_o  out  1  zero the IF/ID register at the next edge
stall_cnt_o  out  CNT_W  count of stall cycles
flush_cnt_o  out  CNT_W  count of taken-branch flushes

Behaviour:
- Opcode decode: uses_rs1 for R, I, LW, SW, BEQ. uses_rs2 for R, SW, BEQ. writes_rd for R, I, LW. is_load for LW only. Any other opcode (including all-zero) decodes as all 0.
- Shadow state: ex_rd, ex_wr, ex_ld, mem_rd, mem_ld.
- Every edge: mem_* <= ex_*.
- If hz=0: ex_rd <= ID_rd_i, ex_wr <= writes_rd, ex_ld <= is_load. If hz=1: ex_* <= 0 (bubble).
- Match X: (X==ID_rs1_i && uses_rs1) || (X==ID_rs2_i && uses_rs2), with X != 0. Register x0 never causes a hazard.
- H_LU: ex_ld && match(ex_rd).
- H_BA: ID_Op_i==BEQ && ex_wr && !ex_ld && match(ex_rd).
- H_BL: ID_Op_i==BEQ && mem_ld && match(mem_rd).
- hz = H_LU | H_BA | H_BL.
- Outputs are combinational, zero latency:
  - NoOp_o = hz, Stall_o = hz, PCWrite_o = !hz.
  - Flush_o = Branch_taken_i && ID_Op_i==BEQ && !hz.
- A branch waiting on a stall is never flushed. A taken branch flushes exactly one cycle.
- Resulting stall counts: ALU/LW producer followed by non-branch consumer: 0 for ALU, 1 for LW. BEQ after ALU: 1. BEQ immediately after LW: 2 (H_LU, then H_BL). BEQ one instruction after LW: 1.
- Counters: stall_cnt += 1 on each cycle with hz=1. flush_cnt += 1 on each cycle with Flush_o=1. Both saturate at all-ones and never wrap.
- Reset, taking effect at the edge while rst_i=1:
  - All shadow state and both counters go to 0.
  - While rst_i=1, the outputs are forced to NoOp_o=0, Stall_o=0, Flush_o=0, PCWrite_o=0, whatever the inputs.
  - After release, the empty shadow gives hz=0 and PCWrite_o=1.
  - Reset in the middle of a multi-cycle stall abandons it. No residual bubble.
- Unknown opcodes in ID never stall and never flush.

Decomposition:
- Shared package riscv_pkg: opcode constants OP_R=0110011, OP_I=0010011, OP_LW=0000011, OP_SW=0100011, OP_BEQ=1100011. The control decoder uses the same constants. The package also holds REG_AW.
- One sub-module, hazard_op_decode: combinational opcode to {uses_rs1, uses_rs2, writes_rd, is_load}.
- Hazard compare, shadow registers and counters stay in the top level.

Test Plan:
- Reset: rst_i=1 for 2 cycles with Branch_taken_i=1 and ID_Op_i=BEQ. Required: all outputs 0, counters 0. First cycle after release with no hazard: PCWrite_o=1.
- Load-use: `lw x5,0(x1)` then `add x6,x5,x2`. Required: exactly 1 cycle of NoOp_o=Stall_o=1, PCWrite_o=0, then the add proceeds; stall_cnt_o=1. The same sequence with `add x6,x0,x2` after `lw x0`: no stall.
- Branch after ALU: `add x7,x1,x2` then `beq x7,x3,L` with Branch_taken_i=1. Required: 1 stall cycle with Flush_o=0, then Flush_o=1 for 1 cycle. stall_cnt_o=1, flush_cnt_o=1.
- Branch after load: `lw x8,4(x0)` then `beq x9,x8,L`. Required: 2 consecutive stall cycles, then Flush_o follows Branch_taken_i. With one independent instruction between them: 1 stall.
- Non-user opcode: `lw x5` followed by an all-zero opcode reading field rs1=5. Required: no stall.
- Saturation: preload stall_cnt to 2^CNT_W−2 via a force, then apply 3 stall cycles. Required: the counter holds at all-ones.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32-subset definitions: opcode constants and register-address width.
// The control decoder and the hazard unit both decode against these values.
package riscv_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Register-usage class of one instruction, as seen by the hazard logic.
  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic is_load;
  } op_class_t;

endpackage

// File: rtl/hazard_op_decode.sv
// Opcode classifier: which register fields an instruction reads and writes.
// Unknown opcodes (including all-zero bubbles) classify as using nothing.
module hazard_op_decode
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  output op_class_t  cls
);

  // Pure lookup from opcode to register-usage flags.
  always_comb begin
    cls = '0;
    unique case (op)
      OP_R: begin
        cls.uses_rs1  = 1'b1;
        cls.uses_rs2  = 1'b1;
        cls.writes_rd = 1'b1;
      end
      OP_I: begin
        cls.uses_rs1  = 1'b1;
        cls.writes_rd = 1'b1;
      end
      OP_LW: begin
        cls.uses_rs1  = 1'b1;
        cls.writes_rd = 1'b1;
        cls.is_load   = 1'b1;
      end
      OP_SW: begin
        cls.uses_rs1 = 1'b1;
        cls.uses_rs2 = 1'b1;
      end
      OP_BEQ: begin
        cls.uses_rs1 = 1'b1;
        cls.uses_rs2 = 1'b1;
      end
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline with branches resolved in ID.
// Tracks the destination/load info of the instructions now in EX and MEM,
// stalls ID on load-use and branch-operand hazards, flushes IF/ID on a taken
// branch, and keeps saturating stall/flush counters.
module hazard_detection_unit #(
  parameter int REG_AW = riscv_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        ID_Op_i,
  input  logic [REG_AW-1:0] ID_rs1_i,
  input  logic [REG_AW-1:0] ID_rs2_i,
  input  logic [REG_AW-1:0] ID_rd_i,
  input  logic              Branch_taken_i,
  output logic              NoOp_o,
  output logic              Stall_o,
  output logic              PCWrite_o,
  output logic              Flush_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  import riscv_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  op_class_t         id_cls;

  // Shadow of the EX and MEM stages (only what the hazard checks need)
  logic [REG_AW-1:0] ex_rd_reg;
  logic              ex_wr_reg;
  logic              ex_ld_reg;
  logic [REG_AW-1:0] mem_rd_reg;
  logic              mem_ld_reg;

  logic              is_beq;
  logic              match_ex;
  logic              match_mem;
  logic              h_lu;
  logic              h_ba;
  logic              h_bl;
  logic              hz;
  logic              flush_raw;

  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;

  hazard_op_decode u_op_decode (
    .op  (ID_Op_i),
    .cls (id_cls)
  );

  // Hazard detection against the in-flight producers; x0 never matches.
  always_comb begin
    is_beq    = (ID_Op_i == OP_BEQ);
    match_ex  = (ex_rd_reg != '0) &&
                (((ex_rd_reg == ID_rs1_i) && id_cls.uses_rs1) ||
                 ((ex_rd_reg == ID_rs2_i) && id_cls.uses_rs2));
    match_mem = (mem_rd_reg != '0) &&
                (((mem_rd_reg == ID_rs1_i) && id_cls.uses_rs1) ||
                 ((mem_rd_reg == ID_rs2_i) && id_cls.uses_rs2));
    h_lu      = ex_ld_reg && match_ex;
    h_ba      = is_beq && ex_wr_reg && !ex_ld_reg && match_ex;
    h_bl      = is_beq && mem_ld_reg && match_mem;
    hz        = h_lu || h_ba || h_bl;
    // A branch held by a stall must not flush until its operands are ready.
    flush_raw = Branch_taken_i && is_beq && !hz;
  end

  // Pipeline control outputs; everything is held inactive during reset.
  always_comb begin
    NoOp_o    = 1'b0;
    Stall_o   = 1'b0;
    PCWrite_o = 1'b0;
    Flush_o   = 1'b0;
    if (!rst_i) begin
      NoOp_o    = hz;
      Stall_o   = hz;
      PCWrite_o = !hz;
      Flush_o   = flush_raw;
    end
  end

  // Shadow advance: ID moves to EX (or a bubble on a stall), EX moves to MEM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_rd_reg  <= '0;
      ex_wr_reg  <= 1'b0;
      ex_ld_reg  <= 1'b0;
      mem_rd_reg <= '0;
      mem_ld_reg <= 1'b0;
    end else begin
      mem_rd_reg <= ex_rd_reg;
      mem_ld_reg <= ex_ld_reg;
      if (hz) begin
        ex_rd_reg <= '0;
        ex_wr_reg <= 1'b0;
        ex_ld_reg <= 1'b0;
      end else begin
        ex_rd_reg <= ID_rd_i;
        ex_wr_reg <= id_cls.writes_rd;
        ex_ld_reg <= id_cls.is_load;
      end
    end
  end

  // Saturating performance counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (hz && (stall_cnt_reg != CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (flush_raw && (flush_cnt_reg != CNT_MAX)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed pipeline sequences
// followed by randomized instruction streams, compared each cycle against a
// reference model that tracks the instructions in flight in EX and MEM.
module tb_hazard_detection_unit;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam longint     MAXC  = 64'h0000_0000_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic        bt;
  logic        noop, stall, pcw, flush;
  logic [31:0] stall_cnt, flush_cnt;

  int check_count = 0;
  int error_count = 0;

  hazard_detection_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ID_Op_i        (op),
    .ID_rs1_i       (rs1),
    .ID_rs2_i       (rs2),
    .ID_rd_i        (rd),
    .Branch_taken_i (bt),
    .NoOp_o         (noop),
    .Stall_o        (stall),
    .PCWrite_o      (pcw),
    .Flush_o        (flush),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instructions currently occupying EX and MEM.
  typedef struct {
    logic [4:0] rd;
    bit         writes;
    bit         load;
  } inflight_t;

  inflight_t in_ex, in_mem;
  longint    m_stalls, m_flushes;
  bit        known;
  bit        exp_hz;

  task automatic check(input string tag, input longint got, input longint exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void classify(input logic [6:0] o, output bit r1, output bit r2,
                                   output bit wr, output bit ld);
    r1 = 0; r2 = 0; wr = 0; ld = 0;
    if (o == T_R)   begin r1 = 1; r2 = 1; wr = 1; end
    if (o == T_I)   begin r1 = 1; wr = 1; end
    if (o == T_LW)  begin r1 = 1; wr = 1; ld = 1; end
    if (o == T_SW)  begin r1 = 1; r2 = 1; end
    if (o == T_BEQ) begin r1 = 1; r2 = 1; end
  endfunction

  // One clock cycle: present an ID instruction, check outputs, advance model.
  task automatic step(input logic r, input logic [6:0] o, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d, input logic t);
    bit r1, r2, wr, ld, reads_ex, reads_mem, is_br, e_flush;
    @(negedge clk);
    rst = r; op = o; rs1 = a; rs2 = b; rd = d; bt = t;
    #1;
    classify(o, r1, r2, wr, ld);
    is_br     = (o == T_BEQ);
    reads_ex  = (in_ex.rd != 0)  && ((in_ex.rd == a && r1)  || (in_ex.rd == b && r2));
    reads_mem = (in_mem.rd != 0) && ((in_mem.rd == a && r1) || (in_mem.rd == b && r2));
    exp_hz    = (in_ex.load && reads_ex) ||
                (is_br && in_ex.writes && !in_ex.load && reads_ex) ||
                (is_br && in_mem.load && reads_mem);
    e_flush   = t && is_br && !exp_hz;
    if (r) begin
      check("noop_rst", noop, 0);
      check("stall_rst", stall, 0);
      check("pcwrite_rst", pcw, 0);
      check("flush_rst", flush, 0);
    end else begin
      check("noop", noop, exp_hz);
      check("stall", stall, exp_hz);
      check("pcwrite", pcw, !exp_hz);
      check("flush", flush, e_flush);
    end
    if (known) begin
      check("stall_cnt", stall_cnt, m_stalls);
      check("flush_cnt", flush_cnt, m_flushes);
    end
    $display("cyc rst=%0d op=%b rs1=%0d rs2=%0d rd=%0d bt=%0d -> noop=%0d stall=%0d pcw=%0d flush=%0d sc=%0d fc=%0d",
             r, o, a, b, d, t, noop, stall, pcw, flush, stall_cnt, flush_cnt);
    if (r) begin
      in_ex = '{0, 0, 0}; in_mem = '{0, 0, 0};
      m_stalls = 0; m_flushes = 0; known = 1;
      exp_hz = 0;
    end else begin
      in_mem = in_ex;
      if (exp_hz) in_ex = '{0, 0, 0};
      else        in_ex = '{d, wr, ld};
      if (exp_hz && m_stalls < MAXC)   m_stalls++;
      if (e_flush && m_flushes < MAXC) m_flushes++;
    end
  endtask

  // Present an instruction in ID until the pipeline accepts it.
  task automatic issue(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic t, output int stalls);
    stalls = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, o, a, b, d, t);
      if (!exp_hz) break;
      stalls++;
    end
  endtask

  task automatic drain();
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    int n;
    int total;
    logic [6:0] ro;
    logic [4:0] ra, rb, rdd;
    in_ex = '{0, 0, 0}; in_mem = '{0, 0, 0};
    m_stalls = 0; m_flushes = 0; known = 0; exp_hz = 0;
    rst = 1; op = '0; rs1 = '0; rs2 = '0; rd = '0; bt = 0;

    // Reset with a taken BEQ sitting in ID: everything must stay inactive.
    step(1'b1, T_BEQ, 5'd1, 5'd2, 5'd0, 1'b1);
    step(1'b1, T_BEQ, 5'd1, 5'd2, 5'd0, 1'b1);
    step(1'b0, T_R, 5'd1, 5'd2, 5'd3, 1'b0);
    check("pcw_after_reset", pcw, 1);
    drain();

    // Load-use: one bubble; lw x0 never stalls.
    issue(T_LW, 5'd1, 5'd0, 5'd5, 1'b0, n);
    issue(T_R, 5'd5, 5'd2, 5'd6, 1'b0, n);
    check("lu_stalls", n, 1);
    check("lu_stall_cnt", stall_cnt, 1);
    drain();
    issue(T_LW, 5'd1, 5'd0, 5'd0, 1'b0, n);
    issue(T_R, 5'd0, 5'd2, 5'd6, 1'b0, n);
    check("lu_x0_stalls", n, 0);
    drain();

    // Branch after ALU: one stall then a single flush.
    issue(T_R, 5'd1, 5'd2, 5'd7, 1'b0, n);
    issue(T_BEQ, 5'd7, 5'd3, 5'd0, 1'b1, n);
    check("ba_stalls", n, 1);
    check("ba_flush", flush, 1);
    drain();

    // Branch right after a load: two stalls; one gap instruction: one stall.
    issue(T_LW, 5'd0, 5'd0, 5'd8, 1'b0, n);
    issue(T_BEQ, 5'd9, 5'd8, 5'd0, 1'b1, n);
    check("bl_stalls", n, 2);
    drain();
    issue(T_LW, 5'd0, 5'd0, 5'd8, 1'b0, n);
    issue(T_R, 5'd1, 5'd2, 5'd10, 1'b0, n);
    issue(T_BEQ, 5'd9, 5'd8, 5'd0, 1'b0, n);
    check("bl_gap_stalls", n, 1);
    drain();

    // Unknown (all-zero) opcode reading the load destination: no stall.
    issue(T_LW, 5'd1, 5'd0, 5'd5, 1'b0, n);
    issue(7'd0, 5'd5, 5'd5, 5'd0, 1'b1, n);
    check("nonuser_stalls", n, 0);
    drain();

    // Saturation: preload stall counter, then three stall cycles.
    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_reg;
    m_stalls = MAXC - 1;
    issue(T_LW, 5'd0, 5'd0, 5'd8, 1'b0, n);
    issue(T_BEQ, 5'd8, 5'd1, 5'd0, 1'b0, n);
    issue(T_LW, 5'd0, 5'd0, 5'd9, 1'b0, n);
    issue(T_R, 5'd9, 5'd9, 5'd4, 1'b0, n);
    drain();
    check("stall_cnt_sat", stall_cnt, MAXC);

    // Reset in the middle of a stall: no residual bubble afterwards.
    issue(T_LW, 5'd0, 5'd0, 5'd8, 1'b0, n);
    step(1'b0, T_BEQ, 5'd8, 5'd1, 5'd0, 1'b1);
    step(1'b1, T_BEQ, 5'd8, 5'd1, 5'd0, 1'b1);
    issue(T_BEQ, 5'd8, 5'd1, 5'd0, 1'b1, n);
    check("rst_mid_stall", n, 0);

    // Randomized instruction stream with occasional resets.
    total = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: ro = T_R;
        1: ro = T_I;
        2: ro = T_LW;
        3: ro = T_SW;
        4: ro = T_BEQ;
        5: ro = 7'd0;
        6: ro = 7'($urandom);
        default: ro = T_LW;
      endcase
      ra  = 5'($urandom_range(0, 7));
      rb  = 5'($urandom_range(0, 7));
      rdd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) begin
        step(1'b1, ro, ra, rb, rdd, 1'($urandom));
      end else begin
        issue(ro, ra, rb, rdd, 1'($urandom), n);
        total += n;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
